// File: rtl/butterfly_pkg.sv
// ---------------------------------------------------------------------------
// butterfly_pkg
// Shared types and default sizes for the RAM butterfly engine.
//   state_t : pass sequencer states (IDLE, READ, WRITE, DONE)
//   mode_t  : subtraction operand order for the W results
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default word width and address width
// ---------------------------------------------------------------------------
package butterfly_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_SUB_XW = 1'b0,
        MODE_SUB_WX = 1'b1
    } mode_t;

endpackage

// File: rtl/dual_port_ram_param.sv
// ---------------------------------------------------------------------------
// dual_port_ram_param
// Plain true dual-port RAM, 2^ADDR_W words of DATA_W bits, no reset.
// Both ports read and write on the rising edge of clk; reads are registered
// (data appears one cycle after the address) and return the pre-write word.
// Ports:
//   clk                          : clock
//   we_a, addr_a, wdata_a, rdata_a : port A write enable / address / data
//   we_b, addr_b, wdata_b, rdata_b : port B write enable / address / data
// ---------------------------------------------------------------------------
module dual_port_ram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Storage and registered read for both ports. Contents are intentionally
    // not reset so an aborted pass leaves whatever was already written.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
        if (we_b) begin
            mem[addr_b] <= wdata_b;
        end
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/ram_butterfly_engine.sv
// ---------------------------------------------------------------------------
// ram_butterfly_engine
// Runs one butterfly pass over two RAMs (W and X). For each pair index i in
// 0..H-1 the engine reads words i and i+H of both RAMs, then writes back
// differences into W and sums into X. A host port gives read/write access
// to either RAM whenever no pass is running.
//
// Build option: define BUTTERFLY_SATURATE_EN to clamp sums to all-ones and
// differences to zero; without it all results wrap modulo 2^DATA_W.
//
// Ports:
//   CLOCK_50_I   : clock (rising edge)
//   RESET_I      : asynchronous active-high reset
//   START_I      : one-cycle pass request, honoured only in IDLE
//   MODE_I       : subtraction order, captured with an accepted START_I
//   BUSY_O       : pass in progress (READ/WRITE cycles)
//   DONE_O       : one-cycle pulse when the pass completes
//   CHECKSUM_O   : XOR of every word written during the last pass
//   HOST_WE_I    : host write strobe (ignored while busy)
//   HOST_SEL_I   : 0 = RAM W, 1 = RAM X
//   HOST_ADDR_I  : host address
//   HOST_DATA_I  : host write data
//   HOST_RDATA_O : selected RAM word, one cycle after the address
// ---------------------------------------------------------------------------
module ram_butterfly_engine
    import butterfly_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLOCK_50_I,
    input  logic              RESET_I,
    input  logic              START_I,
    input  logic              MODE_I,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic [DATA_W-1:0] CHECKSUM_O,
    input  logic              HOST_WE_I,
    input  logic              HOST_SEL_I,
    input  logic [ADDR_W-1:0] HOST_ADDR_I,
    input  logic [DATA_W-1:0] HOST_DATA_I,
    output logic [DATA_W-1:0] HOST_RDATA_O
);

    localparam int IDX_W = ADDR_W - 1;

    state_t            state;
    mode_t             mode_q;
    logic [IDX_W-1:0]  idx;
    logic              host_sel_q;

    logic              engine_active;
    logic              host_we_ok;

    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;

    logic              w_we_a;
    logic              x_we_a;
    logic              pair_we;
    logic [DATA_W-1:0] w_wdata_a;
    logic [DATA_W-1:0] x_wdata_a;

    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;
    logic [DATA_W-1:0] x_rdata_a;
    logic [DATA_W-1:0] x_rdata_b;

    logic [DATA_W-1:0] new_w_a;
    logic [DATA_W-1:0] new_w_b;
    logic [DATA_W-1:0] new_x_a;
    logic [DATA_W-1:0] new_x_b;

    function automatic logic [DATA_W-1:0] bf_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef BUTTERFLY_SATURATE_EN
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        return sum[DATA_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] bf_sub(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef BUTTERFLY_SATURATE_EN
        return (a < b) ? {DATA_W{1'b0}} : (a - b);
`else
        return a - b;
`endif
    endfunction

    // Engine owns both RAM ports only during READ/WRITE; otherwise port A
    // belongs to the host. Port B is engine-only, so it always sits on the
    // upper half of the pair. The upper/lower half bit keeps both addresses
    // inside 0..N-1 by construction.
    always_comb begin
        engine_active = (state == ST_READ) || (state == ST_WRITE);
        host_we_ok    = HOST_WE_I && !engine_active && !RESET_I;
        pair_we       = (state == ST_WRITE) && !RESET_I;
        addr_a        = engine_active ? {1'b0, idx} : HOST_ADDR_I;
        addr_b        = {1'b1, idx};
        w_we_a        = pair_we || (host_we_ok && !HOST_SEL_I);
        x_we_a        = pair_we || (host_we_ok && HOST_SEL_I);
        w_wdata_a     = engine_active ? new_w_a : HOST_DATA_I;
        x_wdata_a     = engine_active ? new_x_a : HOST_DATA_I;
    end

    // Butterfly datapath on the words read in the preceding READ cycle.
    // The mode only swaps the operand order of the two W differences.
    always_comb begin
        new_x_a = bf_add(w_rdata_a, x_rdata_b);
        new_x_b = bf_add(w_rdata_b, x_rdata_a);
        if (mode_q == MODE_SUB_XW) begin
            new_w_a = bf_sub(w_rdata_b, x_rdata_a);
            new_w_b = bf_sub(w_rdata_a, x_rdata_b);
        end else begin
            new_w_a = bf_sub(x_rdata_a, w_rdata_b);
            new_w_b = bf_sub(x_rdata_b, w_rdata_a);
        end
    end

    // Pass sequencer with registered status outputs. BUSY_O drops on the
    // same edge DONE_O rises, so the DONE cycle is already host-accessible
    // and START_I is ignored there by virtue of the state, not BUSY_O.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_SUB_XW;
            idx        <= '0;
            BUSY_O     <= 1'b0;
            DONE_O     <= 1'b0;
            CHECKSUM_O <= '0;
        end else begin
            DONE_O <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START_I) begin
                        state      <= ST_READ;
                        mode_q     <= mode_t'(MODE_I);
                        idx        <= '0;
                        BUSY_O     <= 1'b1;
                        CHECKSUM_O <= '0;
                    end
                end
                ST_READ: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    CHECKSUM_O <= CHECKSUM_O ^ new_w_a ^ new_w_b ^ new_x_a ^ new_x_b;
                    if (idx == {IDX_W{1'b1}}) begin
                        state  <= ST_DONE;
                        BUSY_O <= 1'b0;
                        DONE_O <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The read-data mux follows the select that was present with the
    // address, so it lines up with the registered RAM output.
    always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
        if (RESET_I) begin
            host_sel_q <= 1'b0;
        end else begin
            host_sel_q <= HOST_SEL_I;
        end
    end

    assign HOST_RDATA_O = host_sel_q ? x_rdata_a : w_rdata_a;

    dual_port_ram_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_w (
        .clk     (CLOCK_50_I),
        .we_a    (w_we_a),
        .addr_a  (addr_a),
        .wdata_a (w_wdata_a),
        .rdata_a (w_rdata_a),
        .we_b    (pair_we),
        .addr_b  (addr_b),
        .wdata_b (new_w_b),
        .rdata_b (w_rdata_b)
    );

    dual_port_ram_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_x (
        .clk     (CLOCK_50_I),
        .we_a    (x_we_a),
        .addr_a  (addr_a),
        .wdata_a (x_wdata_a),
        .rdata_a (x_rdata_a),
        .we_b    (pair_we),
        .addr_b  (addr_b),
        .wdata_b (new_x_b),
        .rdata_b (x_rdata_b)
    );

endmodule

// File: tb/tb_ram_butterfly_engine.sv
// ---------------------------------------------------------------------------
// tb_ram_butterfly_engine
// Directed bench for ram_butterfly_engine with DATA_W=8, ADDR_W=2 (N=4, H=2).
// Expected RAM contents and checksums are hand-derived from the butterfly
// equations on the loaded vectors. Honours BUTTERFLY_SATURATE_EN for the
// overflow vector.
// ---------------------------------------------------------------------------
module tb_ram_butterfly_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              startPass;
    logic              modeIn;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic              hostWe;
    logic              hostSel;
    logic [ADDR_W-1:0] hostAddr;
    logic [DATA_W-1:0] hostData;
    logic [DATA_W-1:0] hostRdata;

    int errorCount = 0;
    int checkCount = 0;

    ram_butterfly_engine #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .CLOCK_50_I   (clock),
        .RESET_I      (reset),
        .START_I      (startPass),
        .MODE_I       (modeIn),
        .BUSY_O       (busy),
        .DONE_O       (done),
        .CHECKSUM_O   (checksum),
        .HOST_WE_I    (hostWe),
        .HOST_SEL_I   (hostSel),
        .HOST_ADDR_I  (hostAddr),
        .HOST_DATA_I  (hostData),
        .HOST_RDATA_O (hostRdata)
    );

    // 10 ns clock; inputs are driven and outputs sampled on the falling edge.
    always #5 clock = ~clock;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Host access helpers; each is entered and left on a falling edge.
    task automatic hostWrite(input logic sel, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
        hostWe   = 1'b1;
        hostSel  = sel;
        hostAddr = addr;
        hostData = data;
        @(negedge clock);
        hostWe = 1'b0;
    endtask

    task automatic hostRead(input logic sel, input logic [ADDR_W-1:0] addr,
                            output logic [DATA_W-1:0] data);
        hostWe   = 1'b0;
        hostSel  = sel;
        hostAddr = addr;
        @(negedge clock);
        data = hostRdata;
    endtask

    task automatic loadRams(input logic [7:0] wVals[4], input logic [7:0] xVals[4]);
        for (int k = 0; k < 4; k++) begin
            hostWrite(1'b0, ADDR_W'(k), wVals[k]);
            hostWrite(1'b1, ADDR_W'(k), xVals[k]);
        end
    endtask

    task automatic checkRams(input string tag, input logic [7:0] wExp[4],
                             input logic [7:0] xExp[4]);
        logic [DATA_W-1:0] rd;
        for (int k = 0; k < 4; k++) begin
            hostRead(1'b0, ADDR_W'(k), rd);
            checkOutput($sformatf("%s W[%0d]", tag, k), 32'(rd), 32'(wExp[k]));
            hostRead(1'b1, ADDR_W'(k), rd);
            checkOutput($sformatf("%s X[%0d]", tag, k), 32'(rd), 32'(xExp[k]));
        end
    endtask

    // Issues START in the current cycle (cycle 0) and watches 12 cycles,
    // recording the cycle of the first DONE pulse and how many pulses seen.
    // With disturb set, it re-pulses START and flips MODE at cycles 2 and 4
    // and attempts a host write of 0x55 to W[0] at cycle 2.
    task automatic applyStimulus(input logic mode, input bit disturb,
                                 output int doneAt, output int doneCount);
        startPass = 1'b1;
        modeIn    = mode;
        @(negedge clock);
        startPass = 1'b0;
        doneAt    = -1;
        doneCount = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 1) begin
                checkOutput("busy after start", 32'(busy), 32'd1);
            end
            if (done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = cyc;
                end
            end
            if (disturb && (cyc == 2 || cyc == 4)) begin
                startPass = 1'b1;
                modeIn    = ~mode;
            end else begin
                startPass = 1'b0;
            end
            if (disturb && cyc == 2) begin
                hostWe   = 1'b1;
                hostSel  = 1'b0;
                hostAddr = '0;
                hostData = 8'h55;
            end else begin
                hostWe = 1'b0;
            end
            @(negedge clock);
        end
        startPass = 1'b0;
        hostWe    = 1'b0;
    endtask

    logic [7:0] wInit[4]     = '{8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] xInit[4]     = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [7:0] wMode0[4]    = '{8'd249, 8'd240, 8'd227, 8'd218};
    logic [7:0] wMode1[4]    = '{8'd7, 8'd16, 8'd29, 8'd38};
    logic [7:0] xPass[4]     = '{8'd31, 8'd42, 8'd13, 8'd24};
    logic [7:0] wZero[4]     = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] xFull[4]     = '{8'd255, 8'd255, 8'd255, 8'd255};
    logic [7:0] wOvf[4];
    logic [7:0] wAbort[4]    = '{8'd249, 8'd2, 8'd227, 8'd4};
    logic [7:0] xAbort[4]    = '{8'd31, 8'd20, 8'd13, 8'd40};

    initial begin
        int               doneAt;
        int               doneCount;
        logic [DATA_W-1:0] rd;

`ifdef BUTTERFLY_SATURATE_EN
        wOvf = '{8'd0, 8'd0, 8'd0, 8'd0};
`else
        wOvf = '{8'd1, 8'd1, 8'd1, 8'd1};
`endif

        reset     = 1'b1;
        startPass = 1'b0;
        modeIn    = 1'b0;
        hostWe    = 1'b0;
        hostSel   = 1'b0;
        hostAddr  = '0;
        hostData  = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] pass mode 0");
        loadRams(wInit, xInit);
        applyStimulus(1'b0, 1'b0, doneAt, doneCount);
        checkOutput("mode0 done cycle", 32'(doneAt), 32'd5);
        checkOutput("mode0 done count", 32'(doneCount), 32'd1);
        checkOutput("mode0 checksum", 32'(checksum), 32'h10);
        checkRams("mode0", wMode0, xPass);

        $display("[TB] pass mode 1");
        loadRams(wInit, xInit);
        applyStimulus(1'b1, 1'b0, doneAt, doneCount);
        checkOutput("mode1 done cycle", 32'(doneAt), 32'd5);
        checkOutput("mode1 checksum", 32'(checksum), 32'h0C);
        checkRams("mode1", wMode1, xPass);

        $display("[TB] overflow vector");
        loadRams(wZero, xFull);
        applyStimulus(1'b0, 1'b0, doneAt, doneCount);
        checkOutput("ovf done cycle", 32'(doneAt), 32'd5);
        checkOutput("ovf checksum", 32'(checksum), 32'd0);
        checkRams("ovf", wOvf, xFull);

        $display("[TB] restart, mode change and host write while busy");
        loadRams(wInit, xInit);
        applyStimulus(1'b0, 1'b1, doneAt, doneCount);
        checkOutput("disturb done cycle", 32'(doneAt), 32'd5);
        checkOutput("disturb done count", 32'(doneCount), 32'd1);
        checkOutput("disturb checksum", 32'(checksum), 32'h10);
        checkRams("disturb", wMode0, xPass);

        $display("[TB] host write while idle");
        hostWrite(1'b0, 2'd0, 8'h55);
        hostRead(1'b0, 2'd0, rd);
        checkOutput("idle host write", 32'(rd), 32'h55);

        $display("[TB] reset during WRITE of pair 1");
        loadRams(wInit, xInit);
        startPass = 1'b1;
        modeIn    = 1'b0;
        @(negedge clock);
        startPass = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("abort busy before reset", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort checksum", 32'(checksum), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkRams("abort", wAbort, xAbort);

        $display("[TB] start on first clock after reset release");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, doneAt, doneCount);
        checkOutput("post-reset done cycle", 32'(doneAt), 32'd5);
        checkOutput("post-reset done count", 32'(doneCount), 32'd1);

        $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
